// File: rtl/csam_div.sv
// csam_div - sequential restoring divider, the inverse of the CSAM array
// multiplier. It divides the ZW-bit dividend Z by the YW-bit divisor Y and
// returns quotient X and remainder R such that Z = X*Y + R. It produces one
// quotient bit per clock and uses a start/done handshake.
//
// Optional feature: define CSAM_DIV_EARLY_EXIT_EN to finish Z==0 divisions
// (with Y!=0) in a single cycle instead of the full XW-cycle run.
//
// Ports:
//   clk    in   clock, all state updates on posedge
//   reset  in   synchronous active-high reset, highest priority
//   start  in   request, accepted only in IDLE or DONE
//   Z      in   dividend (XW+YW bits), captured when start is accepted
//   Y      in   divisor (YW bits), captured when start is accepted
//   X      out  quotient (XW bits)
//   R      out  remainder (YW bits)
//   busy   out  high while dividing
//   done   out  one-cycle pulse; X/R/ovf/dz are valid
//   ovf    out  quotient would not fit in XW bits
//   dz     out  divide by zero
module csam_div #(
   parameter int unsigned XW = 8,
   parameter int unsigned YW = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [XW+YW-1:0] Z,
   input  logic [YW-1:0]    Y,
   output logic [XW-1:0]    X,
   output logic [YW-1:0]    R,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             dz
);

   localparam int unsigned ZW = XW + YW;
   localparam int unsigned CW = (XW > 1) ? $clog2(XW) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [YW:0]     p_q, p_d;      // partial remainder, one guard bit
   logic [XW-1:0]   sh_q, sh_d;    // remaining dividend bits, MSB first
   logic [YW-1:0]   y_q, y_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   r_q, r_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            dz_q, dz_d;

   // Trial subtraction for the current iteration. P < Y holds in RUN, so
   // dropping P's guard bit before the shift loses nothing.
   logic [YW:0]     trial;
   logic            trial_ge;
   logic [YW:0]     p_nxt;

   always_comb begin
      trial    = {p_q[YW-1:0], sh_q[XW-1]};
      trial_ge = (trial >= {1'b0, y_q});
      p_nxt    = trial_ge ? (trial - {1'b0, y_q}) : trial;
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      sh_d    = sh_q;
      y_d     = y_q;
      x_d     = x_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               y_d   = Y;
               ovf_d = 1'b0;
               dz_d  = 1'b0;
               cnt_d = '0;
               if (Y == '0) begin
                  dz_d    = 1'b1;
                  x_d     = '1;
                  r_d     = '0;
                  p_d     = '0;
                  sh_d    = '0;
                  state_d = S_DONE;
               end else if (Z[ZW-1:XW] >= Y) begin
                  ovf_d   = 1'b1;
                  x_d     = '1;
                  r_d     = '0;
                  p_d     = '0;
                  sh_d    = '0;
                  state_d = S_DONE;
`ifdef CSAM_DIV_EARLY_EXIT_EN
               end else if (Z == '0) begin
                  x_d     = '0;
                  r_d     = '0;
                  p_d     = '0;
                  sh_d    = '0;
                  state_d = S_DONE;
`endif
               end else begin
                  p_d     = {1'b0, Z[ZW-1:XW]};
                  sh_d    = Z[XW-1:0];
                  x_d     = '0;
                  state_d = S_RUN;
               end
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            p_d   = p_nxt;
            sh_d  = sh_q << 1;
            x_d   = {x_q[XW-2:0], trial_ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XW - 1)) begin
               r_d     = p_nxt[YW-1:0];
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         sh_q    <= '0;
         y_q     <= '0;
         x_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         sh_q    <= sh_d;
         y_q     <= y_d;
         x_q     <= x_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   assign X    = x_q;
   assign R    = r_q;
   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign ovf  = ovf_q;
   assign dz   = dz_q;

endmodule

// File: tb/tb_csam_div.sv
// tb_csam_div - directed self-checking bench for csam_div.
module tb_csam_div;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] Z;
   logic [3:0]  Y;
   logic [7:0]  X;
   logic [3:0]  R;
   logic        busy, done, ovf, dz;

   int n_checks = 0;
   int n_fail   = 0;

   csam_div #(.XW(8), .YW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .Z     (Z),
      .Y     (Y),
      .X     (X),
      .R     (R),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   // Reference CSAM product, 12-bit result.
   function automatic logic [11:0] csam_mul(input logic [7:0] a, input logic [3:0] b);
      return 12'(a) * 12'(b);
   endfunction

   // Launches one operation from a point just after a clock edge and waits
   // for done. lat counts edges from the accepting edge (1 = first edge);
   // bcnt counts sample points with busy high. Bounded wait.
   task automatic run_op(input logic [11:0] z, input logic [3:0] y,
                         output int lat, output int bcnt);
      Z     = z;
      Y     = y;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      bcnt  = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      Z     = '0;
      Y     = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      n_checks++; if (X !== 8'd0)   begin n_fail++; $display("FAIL reset_X got %h want 00", X); end
      n_checks++; if (R !== 4'd0)   begin n_fail++; $display("FAIL reset_R got %h want 0", R); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
      n_checks++; if (dz !== 1'b0)   begin n_fail++; $display("FAIL reset_dz got %b want 0", dz); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat, bcnt;
      run_op(12'd1000, 4'd7, lat, bcnt);
      n_checks++; if (lat !== 9)     begin n_fail++; $display("FAIL basic_latency got %0d want 9", lat); end
      n_checks++; if (bcnt !== 8)    begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 8", bcnt); end
      n_checks++; if (X !== 8'd142)  begin n_fail++; $display("FAIL basic_X got %0d want 142", X); end
      n_checks++; if (R !== 4'd6)    begin n_fail++; $display("FAIL basic_R got %0d want 6", R); end
      n_checks++; if (ovf !== 1'b0 || dz !== 1'b0) begin n_fail++; $display("FAIL basic_flags got ovf=%b dz=%b want 0 0", ovf, dz); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
      n_checks++; if (X !== 8'd142 || R !== 4'd6) begin n_fail++; $display("FAIL basic_hold got X=%0d R=%0d want 142 6", X, R); end
   endtask

   task automatic test_max();
      int lat, bcnt;
      run_op(12'hEFF, 4'hF, lat, bcnt);
      n_checks++; if (lat !== 9)    begin n_fail++; $display("FAIL max_latency got %0d want 9", lat); end
      n_checks++; if (X !== 8'd255) begin n_fail++; $display("FAIL max_X got %0d want 255", X); end
      n_checks++; if (R !== 4'd14)  begin n_fail++; $display("FAIL max_R got %0d want 14", R); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL max_ovf got %b want 0", ovf); end
      @(posedge clk); #1;
      run_op(12'hF00, 4'hF, lat, bcnt);
      n_checks++; if (lat !== 1)    begin n_fail++; $display("FAIL ovf_latency got %0d want 1", lat); end
      n_checks++; if (ovf !== 1'b1 || dz !== 1'b0) begin n_fail++; $display("FAIL ovf_flags got ovf=%b dz=%b want 1 0", ovf, dz); end
      n_checks++; if (X !== 8'hFF || R !== 4'd0) begin n_fail++; $display("FAIL ovf_result got X=%h R=%h want FF 0", X, R); end
      n_checks++; if (bcnt !== 0)   begin n_fail++; $display("FAIL ovf_busy got %0d want 0", bcnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_div_zero();
      int lat, bcnt;
      run_op(12'h123, 4'd0, lat, bcnt);
      n_checks++; if (lat !== 1)    begin n_fail++; $display("FAIL dz_latency got %0d want 1", lat); end
      n_checks++; if (dz !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL dz_flags got dz=%b ovf=%b want 1 0", dz, ovf); end
      n_checks++; if (X !== 8'hFF || R !== 4'd0) begin n_fail++; $display("FAIL dz_result got X=%h R=%h want FF 0", X, R); end
      n_checks++; if (bcnt !== 0)   begin n_fail++; $display("FAIL dz_busy got %0d want 0", bcnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int lat;
      Z = 12'd500; Y = 4'd3; start = 1'b1;
      @(posedge clk); #1;          // edge t
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;          // edge t+4 samples reset
      reset = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl got busy=%b done=%b want 0 0", busy, done); end
      n_checks++; if (X !== 8'd0 || R !== 4'd0 || ovf !== 1'b0 || dz !== 1'b0) begin
         n_fail++; $display("FAIL midreset_out got X=%h R=%h ovf=%b dz=%b want 0", X, R, ovf, dz);
      end
      // New operation; a start pulse with other operands mid-run must be ignored.
      Z = 12'd9; Y = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      repeat (2) begin @(posedge clk); #1; lat++; end
      Z = 12'd100; Y = 4'd7; start = 1'b1;
      @(posedge clk); #1; lat++;
      start = 1'b0;
      while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
      n_checks++; if (lat !== 9)  begin n_fail++; $display("FAIL ignore_start_latency got %0d want 9", lat); end
      n_checks++; if (X !== 8'd4 || R !== 4'd1) begin n_fail++; $display("FAIL ignore_start_result got X=%0d R=%0d want 4 1", X, R); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat, gap;
      Z = 12'd1000; Y = 4'd7; start = 1'b1;
      @(posedge clk); #1;
      Z = 12'd255; Y = 4'd1;       // start stays high throughout the run
      lat = 1;
      while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
      n_checks++; if (X !== 8'd142 || R !== 4'd6) begin n_fail++; $display("FAIL b2b_first got X=%0d R=%0d want 142 6", X, R); end
      @(posedge clk); #1;          // accepting edge in DONE
      start = 1'b0;
      gap = 1;
      while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
      n_checks++; if (gap !== 9)  begin n_fail++; $display("FAIL b2b_gap got %0d want 9", gap); end
      n_checks++; if (X !== 8'd255 || R !== 4'd0) begin n_fail++; $display("FAIL b2b_second got X=%0d R=%0d want 255 0", X, R); end
      @(posedge clk); #1;
   endtask

   task automatic test_sweep();
      int lat, bcnt;
      logic [3:0]  y;
      logic [11:0] z;
      for (int i = 0; i < 1000; i++) begin
         y = 4'($urandom_range(15, 1));
         z = {4'($urandom_range(int'(y) - 1, 0)), 8'($urandom)};
         run_op(z, y, lat, bcnt);
         n_checks++;
         if (csam_mul(X, y) + 12'(R) !== z || R >= y) begin
            n_fail++; $display("FAIL sweep_result z=%0d y=%0d got X=%0d R=%0d", z, y, X, R);
         end
         n_checks++;
         if (lat !== 9 || ovf !== 1'b0 || dz !== 1'b0) begin
            n_fail++; $display("FAIL sweep_ctrl z=%0d y=%0d got lat=%0d ovf=%b dz=%b want 9 0 0", z, y, lat, ovf, dz);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_dividend();
      int lat, bcnt, exp_lat, exp_busy;
`ifdef CSAM_DIV_EARLY_EXIT_EN
      exp_lat = 1; exp_busy = 0;
`else
      exp_lat = 9; exp_busy = 8;
`endif
      run_op(12'd0, 4'd5, lat, bcnt);
      n_checks++; if (lat !== exp_lat)   begin n_fail++; $display("FAIL zero_latency got %0d want %0d", lat, exp_lat); end
      n_checks++; if (bcnt !== exp_busy) begin n_fail++; $display("FAIL zero_busy got %0d want %0d", bcnt, exp_busy); end
      n_checks++; if (X !== 8'd0 || R !== 4'd0 || ovf !== 1'b0 || dz !== 1'b0) begin
         n_fail++; $display("FAIL zero_result got X=%0d R=%0d ovf=%b dz=%b want 0", X, R, ovf, dz);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_div_zero();
      test_reset_mid_run();
      test_back_to_back();
      test_sweep();
      test_zero_dividend();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
